// File: rtl/div_seq_pkg.sv
// Shared defines for the EX-stage divider: state encodings and handshake/reset constants.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        RstEnable         = 1'b1;
  localparam logic        WriteEnable       = 1'b1;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;

endpackage

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// result {HI = remainder, LO = quotient} with a one-cycle HI/LO write strobe.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               hilo_we_o,
  output logic               stallreq_o
);

  localparam int RQ_W = 2 * WIDTH + 1;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    return en ? ((~v) + WIDTH'(1)) : v;
  endfunction

  // Partial remainder lives in the upper WIDTH+1 bits; quotient bits shift in at bit 0.
  function automatic logic [RQ_W-1:0] div_step(input logic [RQ_W-1:0] rq,
                                               input logic [WIDTH-1:0] dvsr);
    logic [WIDTH+1:0] diff;
    logic [RQ_W-1:0]  upd;
    diff = {1'b0, rq[RQ_W-1:WIDTH]} - {2'b00, dvsr};
    upd  = rq;
    if (!diff[WIDTH+1]) upd[RQ_W-1:WIDTH] = diff[WIDTH:0];
    return {upd[RQ_W-2:0], ~diff[WIDTH+1]};
  endfunction

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   counter_q, counter_d;
  logic [RQ_W-1:0]    rq_q, rq_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               signed_q, signed_d;
  logic               op1_neg_q, op1_neg_d;
  logic               op2_neg_q, op2_neg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               hilo_we_q, hilo_we_d;
  logic [RQ_W-1:0]    step_rq;
  logic               in_op1_neg;
  logic               in_op2_neg;

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    rq_d       = rq_q;
    divisor_d  = divisor_q;
    signed_d   = signed_q;
    op1_neg_d  = op1_neg_q;
    op2_neg_d  = op2_neg_q;
    result_d   = result_q;
    ready_d    = ready_q;
    hilo_we_d  = 1'b0;
    step_rq    = div_step(rq_q, divisor_q);
    in_op1_neg = signed_i & opdata1_i[WIDTH-1];
    in_op2_neg = signed_i & opdata2_i[WIDTH-1];

    case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          signed_d  = signed_i;
          op1_neg_d = in_op1_neg;
          op2_neg_d = in_op2_neg;
          divisor_d = neg_if(opdata2_i, in_op2_neg);
          rq_d      = {{WIDTH{1'b0}}, neg_if(opdata1_i, in_op1_neg), 1'b0};
          counter_d = '0;
          state_d   = (opdata2_i == '0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          state_d   = DivEnd;
          result_d  = '0;
          ready_d   = DivResultReady;
          hilo_we_d = WriteEnable;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          rq_d      = step_rq;
          counter_d = counter_q + CNT_W'(1);
          if (counter_q == CNT_W'(WIDTH - 1)) begin
            // Sign fixup on the final step so the result lands with ready.
            state_d   = DivEnd;
            result_d  = {neg_if(step_rq[RQ_W-1:WIDTH+1], signed_q & op1_neg_q),
                         neg_if(step_rq[WIDTH-1:0], signed_q & (op1_neg_q ^ op2_neg_q))};
            ready_d   = DivResultReady;
            hilo_we_d = WriteEnable;
          end
        end
      end
      DivEnd: begin
        if (start_i == DivStop || annul_i) begin
          state_d = DivFree;
          ready_d = DivResultNotReady;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= DivFree;
      counter_q <= '0;
      rq_q      <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      op1_neg_q <= 1'b0;
      op2_neg_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
      hilo_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      rq_q      <= rq_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      op1_neg_q <= op1_neg_d;
      op2_neg_q <= op2_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      hilo_we_q <= hilo_we_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign hilo_we_o  = hilo_we_q;
  assign stallreq_o = start_i & ~annul_i & ~ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vector table, hand-written
// annul/reset sequences and randomized operands against an arithmetic model.
module tb_div_seq;

  localparam int WIDTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          annul_i;
  logic          signed_i;
  logic [31:0]   opdata1_i;
  logic [31:0]   opdata2_i;
  logic [63:0]   result_o;
  logic          ready_o;
  logic          hilo_we_o;
  logic          stallreq_o;

  int vectors = 0;
  int miscompares = 0;

  div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .hilo_we_o (hilo_we_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating division, remainder takes dividend sign.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one divide, hold start until ready, then release; checks timing and strobe.
  task automatic run_div(input string name, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    int stall_bad;
    int early_we;
    logic [63:0] held;
    lat       = -1;
    stall_bad = 0;
    early_we  = 0;
    start_i   = 1'b1;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    #1;
    for (int k = 1; k <= 60; k++) begin
      if (stallreq_o !== 1'b1) stall_bad++;
      tick();
      if (ready_o === 1'b1) begin
        lat = k;
        break;
      end
      if (hilo_we_o !== 1'b0) early_we++;
    end
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " result"}, result_o, exp);
    chk({name, " stall while busy"}, 64'(stall_bad + early_we), 64'h0);
    if (lat < 0) begin
      start_i = 1'b0;
      tick();
      tick();
      return;
    end
    chk({name, " we first END"}, 64'(hilo_we_o), 64'h1);
    chk({name, " stall drops"}, 64'(stallreq_o), 64'h0);
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    held = result_o;
    tick();
    chk({name, " we single"}, {hilo_we_o, ready_o}, 64'b01);
    start_i = 1'b0;
    tick();
    chk({name, " release"}, {hilo_we_o, ready_o}, 64'b00);
    chk({name, " result held"}, result_o, held);
  endtask

  vec_t tbl[$];

  initial begin
    rst       = 1'b1;
    start_i   = 1'b0;
    annul_i   = 1'b0;
    signed_i  = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset outputs", {result_o, 32'h0}, 96'h0);
    chk("reset flags", {ready_o, hilo_we_o, stallreq_o}, 64'h0);

    tbl.push_back('{0, 32'd100,        32'd7,        {32'd2, 32'd14},              33});
    tbl.push_back('{1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33});
    tbl.push_back('{1, 32'd7,          32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD},      33});
    tbl.push_back('{1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h0, 32'h8000_0000},      33});
    tbl.push_back('{0, 32'hFFFF_FFFF,  32'd1,        {32'h0, 32'hFFFF_FFFF},       33});
    tbl.push_back('{0, 32'h0000_1234,  32'd0,        64'h0,                        2});
    tbl.push_back('{0, 32'hFFFF_FFFF,  32'h8000_0000, {32'h7FFF_FFFF, 32'd1},      33});
    tbl.push_back('{0, 32'hFFFF_FFFF,  32'hFFFF_FFFE, {32'd1, 32'd1},              33});
    tbl.push_back('{1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'd3},      33});
    tbl.push_back('{0, 32'd5,          32'd9,        {32'd5, 32'd0},               33});
    foreach (tbl[i]) run_div($sformatf("vec%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b,
                             tbl[i].exp, tbl[i].lat);

    // Annul in the middle of ON: no ready, no strobe, then a clean restart.
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    for (int k = 0; k < 10; k++) tick();
    annul_i = 1'b1;
    #1;
    chk("annul stall", 64'(stallreq_o), 64'h0);
    tick();
    start_i = 1'b0;
    annul_i = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
        if (ready_o !== 1'b0 || hilo_we_o !== 1'b0) seen++;
        tick();
      end
      chk("annul no result", 64'(seen), 64'h0);
    end
    run_div("after annul 9/3", 0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Byzero annulled: must not complete either.
    start_i   = 1'b1;
    opdata1_i = 32'd4;
    opdata2_i = 32'd0;
    tick();
    start_i = 1'b0;
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    tick();
    chk("byzero annul", {ready_o, hilo_we_o}, 64'h0);

    // Reset mid-ON after a non-zero result sits on result_o.
    run_div("pre-reset 50/5", 0, 32'd50, 32'd5, {32'd0, 32'd10}, 33);
    start_i   = 1'b1;
    opdata1_i = 32'd77;
    opdata2_i = 32'd4;
    for (int k = 0; k < 5; k++) tick();
    rst     = 1'b1;
    start_i = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid reset result", result_o, 64'h0);
    chk("mid reset flags", {ready_o, hilo_we_o}, 64'h0);
    run_div("post-reset 77/4", 0, 32'd77, 32'd4, {32'd1, 32'd19}, 33);

    for (int n = 0; n < 150; n++) begin
      bit          sgn;
      logic [31:0] a;
      logic [31:0] b;
      sgn = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 16));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        3: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_div($sformatf("rnd%0d", n), sgn, a, b, ref_div(sgn, a, b), (b == 32'h0) ? 2 : 33);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Iterative radix-2 restoring divider and sequencer for the HI/LO register.
- Sits in EX beside the multiplier.
- Accepts DIV/DIVU operands with a start/ready handshake and stalls the pipeline while busy.
- Delivers remainder (HI) and quotient (LO) with a one-cycle HI/LO write strobe.
- Supports annul on pipeline flush.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  divide request, held by EX until ready_o observed
- annul_i  in  1  flush: abort in-flight divide
- signed_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  WIDTH  dividend, sampled on accept
- opdata2_i  in  WIDTH  divisor, sampled on accept
- result_o  out  2*WIDTH  {HI = remainder, LO = quotient}
- ready_o  out  1  result valid
- hilo_we_o  out  1  one-cycle write strobe toward HI/LO register
- stallreq_o  out  1  pipeline stall request

Behaviour:
- Reset (any state, including mid-divide): state=FREE, result_o=0, ready_o=0, hilo_we_o=0, counter=0, operand registers=0.
- States: FREE, BYZERO, ON, END; all outputs registered except stallreq_o.
- FREE
  - start_i=1 and annul_i=0 accepts the request.
  - Accept latches signed_i and the operand magnitudes (two's-complement negate when signed_i and MSB=1).
  - Divisor==0 -> BYZERO; otherwise -> ON with counter=0 and dividend register = {WIDTH'0, |op1|, 1'b0}.
  - start_i=0 or annul_i=1 -> stay FREE.
- BYZERO -> END next cycle with result_o=0 (HI=0, LO=0).
- ON, each cycle:
  - Trial subtract: upper WIDTH+1 bits minus {1'b0, |divisor|}.
  - Non-negative: replace upper bits, shift left, insert 1. Negative: shift left, insert 0.
  - counter++. On the step with counter==WIDTH-1 -> END.
  - Sign fixup computed in the transition cycle: quotient negated iff signed and op1/op2 signs differ; remainder negated iff signed and op1 negative.
- END
  - ready_o=1 and result_o loaded.
  - hilo_we_o=1 only in the first END cycle.
  - Stays in END while start_i=1; start_i=0 -> FREE with ready_o=0, result_o held.
- annul_i=1 in BYZERO or ON -> FREE next cycle; no ready_o, no hilo_we_o.
- annul_i in END: returns to FREE; the HI/LO write is already committed if the strobe has fired.
- Latency: request accepted at cycle N.
  - ON occupies N+1..N+WIDTH; ready_o and hilo_we_o are high at N+WIDTH+1 (N+33 for WIDTH=32).
  - Divide-by-zero: ready_o at N+2.
- stallreq_o = start_i & ~annul_i & ~ready_o (combinational); it deasserts in the cycle ready_o rises.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. Wraps silently, no exception.
- start_i rising while in ON or BYZERO is ignored. Operands are not re-sampled until FREE.

Decomposition:
- Shared defines package holds:
  - state encodings (DivFree, DivByZero, DivOn, DivEnd)
  - DivStart/DivStop and DivResultReady/DivResultNotReady constants
  - existing RstEnable, WriteEnable, ZeroWord
- No sub-module. The trial-subtract/shift step and the abs/negate logic stay as local combinational functions.

Test Plan:
- DIVU 100 / 7 -> ready_o at N+33, LO=14, HI=2, hilo_we_o high exactly one cycle, stallreq_o high N..N+32.
- DIV -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIV 7 / -2 -> LO=-3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 0xFFFFFFFF / 1 -> LO=0xFFFFFFFF, HI=0.
- Divisor 0 (op1 = 0x1234) -> ready_o at N+2, result_o=0, single hilo_we_o.
- annul_i at N+10 -> FREE at N+11, no ready_o/hilo_we_o. Restart 9/3 -> LO=3, HI=0 at the normal latency.
- rst asserted mid-ON at N+5 -> all outputs 0 next cycle, state FREE. start_i held low in END -> FREE and ready_o=0 next cycle.
